// File: rtl/cmp_hazard_ctrl_if.sv
// Decode-stage hazard interface: D-instruction descriptor in, stall/forward
// decisions and the stall-cycle counter out.
interface cmp_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int TN_W  = 2,
  parameter int CNT_W = 16
);
  logic             D_valid;
  logic [REG_W-1:0] D_rs;
  logic [REG_W-1:0] D_rt;
  logic [TN_W-1:0]  D_tuse_rs;
  logic [TN_W-1:0]  D_tuse_rt;
  logic [REG_W-1:0] D_wreg;
  logic [TN_W-1:0]  D_tnew;
  logic             stall;
  logic [1:0]       fwd_rs_sel;
  logic [1:0]       fwd_rt_sel;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output D_valid, D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_wreg, D_tnew,
    input  stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
  );

  modport slave (
    input  D_valid, D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_wreg, D_tnew,
    output stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
  );
endinterface

// File: rtl/cmp_hazard_ctrl.sv
// Hazard/forwarding controller for the decode-stage branch comparator.
// Tracks E/M/W destination registers and their remaining Tnew.
module cmp_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int TN_W  = 2,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               reset,
  cmp_hazard_ctrl_if.slave  dif
);

  typedef enum logic [1:0] {
    SRC_GRF = 2'd0,
    SRC_E   = 2'd1,
    SRC_M   = 2'd2,
    SRC_W   = 2'd3
  } src_e;

  typedef struct packed {
    logic [REG_W-1:0] rg;
    logic [TN_W-1:0]  tnew;
  } entry_t;

  localparam logic [TN_W-1:0] TUSE_NONE = '1;

  // Index 0 = E, 1 = M, 2 = W (youngest first).
  entry_t           ent_q [3];
  entry_t           ent_d [3];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [2:0] rs_res;
  logic [2:0] rt_res;
  logic       stall_w;

  function automatic logic [TN_W-1:0] age(input logic [TN_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // Returns {pending, select}. Only the youngest matching stage is consulted,
  // so an older ready copy can never mask a younger in-flight write.
  function automatic logic [2:0] resolve(input entry_t e0, input entry_t e1,
                                         input entry_t e2,
                                         input logic [REG_W-1:0] x,
                                         input logic [TN_W-1:0]  tuse);
    logic pend;
    src_e sel;
    pend = 1'b0;
    sel  = SRC_GRF;
    if (x != '0 && tuse != TUSE_NONE) begin
      if (e0.rg == x) begin
        pend = (e0.tnew > tuse);
        if (e0.tnew == '0) sel = SRC_E;
      end else if (e1.rg == x) begin
        pend = (e1.tnew > tuse);
        if (e1.tnew == '0) sel = SRC_M;
      end else if (e2.rg == x) begin
        pend = (e2.tnew > tuse);
        if (e2.tnew == '0) sel = SRC_W;
      end
    end
    return {pend, sel};
  endfunction

  // NOTE: every output of an always_comb gets a default first, so no path
  // can leave a value unassigned and infer a latch.
  always_comb begin
    rs_res  = resolve(ent_q[0], ent_q[1], ent_q[2], dif.D_rs, dif.D_tuse_rs);
    rt_res  = resolve(ent_q[0], ent_q[1], ent_q[2], dif.D_rt, dif.D_tuse_rt);
    stall_w = dif.D_valid & (rs_res[2] | rt_res[2]);

    dif.stall      = stall_w;
    dif.fwd_rs_sel = dif.D_valid ? rs_res[1:0] : SRC_GRF;
    dif.fwd_rt_sel = dif.D_valid ? rt_res[1:0] : SRC_GRF;
    dif.stall_cnt  = cnt_q;
  end

  always_comb begin
    ent_d[2] = '{rg: ent_q[1].rg, tnew: age(ent_q[1].tnew)};
    ent_d[1] = '{rg: ent_q[0].rg, tnew: age(ent_q[0].tnew)};
    ent_d[0] = '0;
    if (dif.D_valid && !stall_w)
      ent_d[0] = '{rg: dif.D_wreg, tnew: dif.D_tnew};

    cnt_d = cnt_q;
    if (stall_w && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q <= '{default: '0};
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cmp_hazard_ctrl.sv
// Directed bench for cmp_hazard_ctrl: a pipeline-occupancy model is checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_cmp_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int TN_W  = 2;
  localparam int CNT_W = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic reset;

  cmp_hazard_ctrl_if #(.REG_W(REG_W), .TN_W(TN_W), .CNT_W(CNT_W)) dif ();

  cmp_hazard_ctrl #(.REG_W(REG_W), .TN_W(TN_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .dif   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: which register each in-flight instruction writes and how many
  // cycles remain until it can be forwarded. Slot 0 = E, 1 = M, 2 = W.
  int  m_reg  [3];
  int  m_tnew [3];
  int  m_cnt;
  bit  started = 0;

  // For one operand: the youngest producer of that register decides.
  function automatic void operand(input int x, input int tuse,
                                  output bit pend, output int sel);
    pend = 0;
    sel  = 0;
    if (x == 0 || tuse == 3) return;
    for (int s = 0; s < 3; s++) begin
      if (m_reg[s] == x) begin
        pend = (m_tnew[s] > tuse);
        sel  = (m_tnew[s] == 0) ? s + 1 : 0;
        return;
      end
    end
  endfunction

  function automatic void expect_out(output bit st, output int srs, output int srt);
    bit p_rs, p_rt;
    operand(int'(dif.D_rs), int'(dif.D_tuse_rs), p_rs, srs);
    operand(int'(dif.D_rt), int'(dif.D_tuse_rt), p_rt, srt);
    st = dif.D_valid && (p_rs || p_rt);
    if (!dif.D_valid) begin
      srs = 0;
      srt = 0;
    end
  endfunction

  always @(posedge clk) begin
    bit st;
    int srs, srt;
    started <= 1'b1;
    if (reset) begin
      for (int s = 0; s < 3; s++) begin
        m_reg[s]  = 0;
        m_tnew[s] = 0;
      end
      m_cnt = 0;
    end else begin
      expect_out(st, srs, srt);
      if (st && m_cnt < CNT_MAX) m_cnt++;
      for (int s = 2; s > 0; s--) begin
        m_reg[s]  = m_reg[s-1];
        m_tnew[s] = (m_tnew[s-1] > 0) ? m_tnew[s-1] - 1 : 0;
      end
      m_reg[0]  = (dif.D_valid && !st) ? int'(dif.D_wreg) : 0;
      m_tnew[0] = (dif.D_valid && !st) ? int'(dif.D_tnew) : 0;
    end
  end

  always @(negedge clk) begin
    bit st;
    int srs, srt;
    if (started) begin
      expect_out(st, srs, srt);
      check("model.stall",      int'(dif.stall),      int'(st));
      check("model.fwd_rs_sel", int'(dif.fwd_rs_sel), srs);
      check("model.fwd_rt_sel", int'(dif.fwd_rt_sel), srt);
      check("model.stall_cnt",  int'(dif.stall_cnt),  m_cnt);
    end
  end

  task automatic set_d(input bit v, input int rs, input int trs, input int rt,
                       input int trt, input int wreg, input int tnew);
    dif.D_valid   = v;
    dif.D_rs      = REG_W'(rs);
    dif.D_tuse_rs = TN_W'(trs);
    dif.D_rt      = REG_W'(rt);
    dif.D_tuse_rt = TN_W'(trt);
    dif.D_wreg    = REG_W'(wreg);
    dif.D_tnew    = TN_W'(tnew);
  endtask

  // Apply a new D instruction just after an edge, then settle to mid-cycle.
  task automatic cyc(input bit v, input int rs, input int trs, input int rt,
                     input int trt, input int wreg, input int tnew);
    @(posedge clk);
    #1;
    set_d(v, rs, trs, rt, trt, wreg, tnew);
    @(negedge clk);
    #1;
  endtask

  task automatic hold();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set_d(0, 0, 3, 0, 3, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    set_d(1, 5, 0, 0, 3, 0, 0);
    @(negedge clk);
    #1;
    check("reset.stall", int'(dif.stall), 0);
    check("reset.fwd_rs", int'(dif.fwd_rs_sel), 0);
    check("reset.cnt", int'(dif.stall_cnt), 0);

    // Load (tnew 2) feeding a branch compare: two stalls, then W forwards.
    cyc(1, 0, 3, 0, 3, 8, 2);
    check("lw.issue_stall", int'(dif.stall), 0);
    cyc(1, 8, 0, 0, 3, 0, 0);
    check("lw.stall1", int'(dif.stall), 1);
    hold();
    check("lw.stall2", int'(dif.stall), 1);
    hold();
    check("lw.release", int'(dif.stall), 0);
    check("lw.fwd_rs", int'(dif.fwd_rs_sel), 3);
    check("lw.cnt", int'(dif.stall_cnt), 2);

    // ALU (tnew 1) feeding a branch: one stall, then forward from M.
    cyc(1, 0, 3, 0, 3, 9, 1);
    cyc(1, 0, 3, 9, 0, 0, 0);
    check("alu.stall", int'(dif.stall), 1);
    hold();
    check("alu.release", int'(dif.stall), 0);
    check("alu.fwd_rt", int'(dif.fwd_rt_sel), 2);
    check("alu.cnt", int'(dif.stall_cnt), 3);

    // ALU feeding an E-stage consumer: no stall, result not yet in E.
    cyc(1, 0, 3, 0, 3, 9, 1);
    cyc(1, 0, 3, 9, 1, 0, 0);
    check("alu_e.stall", int'(dif.stall), 0);
    check("alu_e.fwd_rt", int'(dif.fwd_rt_sel), 0);

    // lui (tnew 0) feeding an E-stage consumer: forward straight from E.
    cyc(1, 0, 3, 0, 3, 10, 0);
    cyc(1, 0, 3, 10, 1, 0, 0);
    check("lui_e.stall", int'(dif.stall), 0);
    check("lui_e.fwd_rt", int'(dif.fwd_rt_sel), 1);

    // Two writers of $4: the younger pending one blocks the older ready one.
    cyc(1, 0, 3, 0, 3, 4, 0);
    cyc(1, 0, 3, 0, 3, 4, 1);
    cyc(1, 4, 0, 0, 3, 0, 0);
    check("prio.stall", int'(dif.stall), 1);
    check("prio.fwd_rs_pending", int'(dif.fwd_rs_sel), 0);
    hold();
    check("prio.release", int'(dif.stall), 0);
    check("prio.fwd_rs_m", int'(dif.fwd_rs_sel), 2);

    // $0 never matches; tuse 3 operands are ignored.
    cyc(1, 0, 3, 0, 3, 0, 2);
    cyc(1, 0, 0, 0, 3, 7, 2);
    check("zero.stall", int'(dif.stall), 0);
    check("zero.fwd_rs", int'(dif.fwd_rs_sel), 0);
    cyc(1, 0, 0, 7, 3, 0, 0);
    check("unused.stall", int'(dif.stall), 0);
    check("unused.fwd_rs", int'(dif.fwd_rs_sel), 0);
    check("unused.fwd_rt", int'(dif.fwd_rt_sel), 0);

    // Reset in the middle of a load stall clears everything.
    cyc(1, 0, 3, 0, 3, 8, 2);
    cyc(1, 8, 0, 0, 3, 0, 0);
    check("rst_mid.stall", int'(dif.stall), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_d(0, 8, 0, 8, 0, 0, 0);
    @(negedge clk);
    #1;
    check("rst_mid.stall_after", int'(dif.stall), 0);
    check("rst_mid.fwd_rs", int'(dif.fwd_rs_sel), 0);
    check("rst_mid.fwd_rt", int'(dif.fwd_rt_sel), 0);
    check("rst_mid.cnt", int'(dif.stall_cnt), 0);
    cyc(1, 8, 0, 0, 3, 0, 0);
    check("rst_mid.empty_sb", int'(dif.stall), 0);

    // Self-hazarding instruction ($8 <- f($8), tnew 3): three stalls out of
    // every four cycles, well past 2^16 + 5 stall cycles in total.
    cyc(1, 8, 0, 0, 3, 8, 3);
    repeat (87400) @(posedge clk);
    @(negedge clk);
    #1;
    check("sat.cnt", int'(dif.stall_cnt), CNT_MAX);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
